hazard_sb: RTL and testbench

- Parametrised successor of the 5-stage hazard unit: E-stage forwarding for NSRC operand channels, D-stage interlock, and F..W stall/flush generation.
- Adds three things:
  - a per-register scoreboard for variable-latency writers (div/mul/CP0), which stalls D until their results retire;
  - a load-use interlock;
  - flush replay. Pipeline registers give stall priority over flush, so a flush that coincides with a stall is latched and applied when that stage's stall drops.

---
 rtl/hazard_sb.sv | 170 +++++++++++++++++
 tb/tb_hazard_sb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sb.sv
// Hazard unit with E-stage forwarding, load-use and scoreboard interlocks, and flush replay.
// Optional macro HAZARD_PERF_CNT_EN adds saturating il/d-cache/replay performance counters.
module hazard_sb #(
    parameter int NSRC = 2,
    parameter int RW   = 5,
    parameter int NREG = 32,
    parameter int LW_  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                d_cache_stall,
    input  logic                i_cache_stall,
    input  logic                alu_stallE,
    input  logic                flush_jump_conflictE,
    input  logic                flush_pred_failedM,
    input  logic                flush_exceptionM,
    input  logic [NSRC*RW-1:0]  srcD,
    input  logic [NSRC-1:0]     src_validD,
    input  logic [NSRC*RW-1:0]  srcE,
    input  logic                regwriteE,
    input  logic                mem_readE,
    input  logic [RW-1:0]       writeregE,
    input  logic                lat_issueE,
    input  logic [LW_-1:0]      lat_cyclesE,
    input  logic                regwriteM,
    input  logic [RW-1:0]       writeregM,
    input  logic                regwriteW,
    input  logic [RW-1:0]       writeregW,
    output logic                stallF,
    output logic                stallD,
    output logic                stallE,
    output logic                stallM,
    output logic                stallW,
    output logic                flushF,
    output logic                flushD,
    output logic                flushE,
    output logic                flushM,
    output logic                flushW,
    output logic [NSRC*2-1:0]   forwardE,
    output logic [NREG-1:0]     sb_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         perf_il_cnt,
    output logic [31:0]         perf_dc_cnt,
    output logic [31:0]         perf_replay_cnt
`endif
);

    logic            load_use;
    logic            sb_hit;
    logic            il;
    logic            f_d, f_e, f_m;
    logic            pend_d, pend_e, pend_m;
    logic            issue;
    logic [LW_-1:0]  sb_cnt [NREG];

    // MEM result is newer than WB, so it takes priority; register 0 is hardwired.
    always_comb begin
        forwardE = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (srcE[k*RW +: RW] != '0 && regwriteM && srcE[k*RW +: RW] == writeregM)
                forwardE[k*2 +: 2] = 2'b01;
            else if (srcE[k*RW +: RW] != '0 && regwriteW && srcE[k*RW +: RW] == writeregW)
                forwardE[k*2 +: 2] = 2'b10;
        end
    end

    always_comb begin
        load_use = 1'b0;
        sb_hit   = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (src_validD[k]) begin
                if (srcD[k*RW +: RW] != '0 && mem_readE && regwriteE &&
                    srcD[k*RW +: RW] == writeregE)
                    load_use = 1'b1;
                if (sb_busy[srcD[k*RW +: RW]])
                    sb_hit = 1'b1;
            end
        end
    end

    assign il = load_use | sb_hit;

    assign stallM = d_cache_stall;
    assign stallW = d_cache_stall;
    assign stallE = d_cache_stall | alu_stallE;
    assign stallD = stallE | il | i_cache_stall;
    assign stallF = stallD & ~flush_exceptionM;

    assign f_d = flush_exceptionM | flush_pred_failedM |
                 (flush_jump_conflictE & ~d_cache_stall);
    assign f_e = flush_exceptionM | (flush_pred_failedM & ~alu_stallE) | (il & ~stallE);
    assign f_m = flush_exceptionM;

    // A stalled stage cannot take a flush now, so the pend bit replays it once the stall drops.
    assign flushF = 1'b0;
    assign flushD = (f_d | pend_d) & ~stallD;
    assign flushE = (f_e | pend_e) & ~stallE;
    assign flushM = (f_m | pend_m) & ~stallM;
    assign flushW = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_d <= 1'b0;
            pend_e <= 1'b0;
            pend_m <= 1'b0;
        end else begin
            if (flushD)
                pend_d <= 1'b0;
            else if (f_d && stallD)
                pend_d <= 1'b1;
            if (flushE)
                pend_e <= 1'b0;
            else if (f_e && stallE)
                pend_e <= 1'b1;
            if (flushM)
                pend_m <= 1'b0;
            else if (f_m && stallM)
                pend_m <= 1'b1;
        end
    end

    assign issue = lat_issueE && regwriteE && writeregE != '0 && lat_cyclesE != '0 &&
                   !stallE && !flush_exceptionM;

    // Counters retire results as W advances; a new issue overrides both reload and retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_busy <= '0;
            for (int r = 0; r < NREG; r++)
                sb_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (issue && writeregE == RW'(r)) begin
                    sb_busy[r] <= 1'b1;
                    sb_cnt[r]  <= lat_cyclesE;
                end else if (sb_busy[r] && !stallW) begin
                    sb_cnt[r] <= sb_cnt[r] - 1'b1;
                    if (sb_cnt[r] == LW_'(1))
                        sb_busy[r] <= 1'b0;
                end
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [1:0]  replay_n;
    logic [32:0] replay_sum;

    assign replay_n = {1'b0, pend_d & ~f_d & ~stallD} +
                      {1'b0, pend_e & ~f_e & ~stallE} +
                      {1'b0, pend_m & ~f_m & ~stallM};
    assign replay_sum = {1'b0, perf_replay_cnt} + {31'd0, replay_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_il_cnt     <= '0;
            perf_dc_cnt     <= '0;
            perf_replay_cnt <= '0;
        end else begin
            if (il && perf_il_cnt != '1)
                perf_il_cnt <= perf_il_cnt + 32'd1;
            if (d_cache_stall && perf_dc_cnt != '1)
                perf_dc_cnt <= perf_dc_cnt + 32'd1;
            perf_replay_cnt <= replay_sum[32] ? '1 : replay_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: per-cycle reference model plus directed literal checks.
module tb_hazard_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_cache_stall, i_cache_stall, alu_stallE;
    logic        flush_jump_conflictE, flush_pred_failedM, flush_exceptionM;
    logic [9:0]  srcD, srcE;
    logic [1:0]  src_validD;
    logic        regwriteE, mem_readE, lat_issueE;
    logic [4:0]  writeregE, writeregM, writeregW;
    logic [5:0]  lat_cyclesE;
    logic        regwriteM, regwriteW;
    logic        stallF, stallD, stallE, stallM, stallW;
    logic        flushF, flushD, flushE, flushM, flushW;
    logic [3:0]  forwardE;
    logic [31:0] sb_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_il_cnt, perf_dc_cnt, perf_replay_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    hazard_sb dut (
        .clk(clk), .rst(rst),
        .d_cache_stall(d_cache_stall), .i_cache_stall(i_cache_stall),
        .alu_stallE(alu_stallE),
        .flush_jump_conflictE(flush_jump_conflictE),
        .flush_pred_failedM(flush_pred_failedM),
        .flush_exceptionM(flush_exceptionM),
        .srcD(srcD), .src_validD(src_validD), .srcE(srcE),
        .regwriteE(regwriteE), .mem_readE(mem_readE), .writeregE(writeregE),
        .lat_issueE(lat_issueE), .lat_cyclesE(lat_cyclesE),
        .regwriteM(regwriteM), .writeregM(writeregM),
        .regwriteW(regwriteW), .writeregW(writeregW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .forwardE(forwardE), .sb_busy(sb_busy)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_il_cnt(perf_il_cnt), .perf_dc_cnt(perf_dc_cnt), .perf_replay_cnt(perf_replay_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Advance to just after the next rising edge and return all inputs to idle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        d_cache_stall = 0; i_cache_stall = 0; alu_stallE = 0;
        flush_jump_conflictE = 0; flush_pred_failedM = 0; flush_exceptionM = 0;
        srcD = '0; src_validD = '0; srcE = '0;
        regwriteE = 0; mem_readE = 0; writeregE = '0; lat_issueE = 0; lat_cyclesE = '0;
        regwriteM = 0; writeregM = '0; regwriteW = 0; writeregW = '0;
    endtask

    // Reference model: remaining cycles per register and an owed-flush flag per stage.
    int   rem [32];
    int   n_rem [32];
    bit   owe_d, owe_e, owe_m, n_owe_d, n_owe_e, n_owe_m;
    logic [3:0]  e_fw;
    logic [4:0]  s;
    logic        e_il, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM, e_xD, e_xE, e_xM, m_issue;
    logic [31:0] e_busy;

    initial begin
        for (int r = 0; r < 32; r++) rem[r] = 0;
        owe_d = 0; owe_e = 0; owe_m = 0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            s = srcE[k*5 +: 5];
            if (s != 0 && regwriteM && s == writeregM)      e_fw[k*2 +: 2] = 2'b01;
            else if (s != 0 && regwriteW && s == writeregW) e_fw[k*2 +: 2] = 2'b10;
            else                                            e_fw[k*2 +: 2] = 2'b00;
        end
        e_il = 0;
        for (int k = 0; k < 2; k++) begin
            s = srcD[k*5 +: 5];
            if (src_validD[k] && s != 0 && mem_readE && regwriteE && s == writeregE) e_il = 1;
            if (src_validD[k] && rem[s] > 0) e_il = 1;
        end
        for (int r = 0; r < 32; r++) e_busy[r] = (rem[r] > 0);
        e_sM = d_cache_stall;
        e_sE = d_cache_stall | alu_stallE;
        e_sD = e_sE | e_il | i_cache_stall;
        e_fD = flush_exceptionM | flush_pred_failedM | (flush_jump_conflictE & ~d_cache_stall);
        e_fE = flush_exceptionM | (flush_pred_failedM & ~alu_stallE) | (e_il & ~e_sE);
        e_fM = flush_exceptionM;
        e_xD = (e_fD | owe_d) & ~e_sD;
        e_xE = (e_fE | owe_e) & ~e_sE;
        e_xM = (e_fM | owe_m) & ~e_sM;

        checkOutput("forwardE", {60'd0, forwardE}, {60'd0, e_fw});
        checkOutput("stalls", {59'd0, stallF, stallD, stallE, stallM, stallW},
                    {59'd0, e_sD & ~flush_exceptionM, e_sD, e_sE, e_sM, e_sM});
        checkOutput("flushes", {59'd0, flushF, flushD, flushE, flushM, flushW},
                    {59'd0, 1'b0, e_xD, e_xE, e_xM, 1'b0});
        checkOutput("sb_busy", {32'd0, sb_busy}, {32'd0, e_busy});

        m_issue = lat_issueE && regwriteE && writeregE != 0 && lat_cyclesE != 0 &&
                  !e_sE && !flush_exceptionM;
        for (int r = 0; r < 32; r++) begin
            if (m_issue && writeregE == r)   n_rem[r] = int'(lat_cyclesE);
            else if (rem[r] > 0 && !e_sM)    n_rem[r] = rem[r] - 1;
            else                             n_rem[r] = rem[r];
        end
        n_owe_d = e_xD ? 1'b0 : ((e_fD && e_sD) ? 1'b1 : owe_d);
        n_owe_e = e_xE ? 1'b0 : ((e_fE && e_sE) ? 1'b1 : owe_e);
        n_owe_m = e_xM ? 1'b0 : ((e_fM && e_sM) ? 1'b1 : owe_m);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) rem[r] <= 0;
            owe_d <= 0; owe_e <= 0; owe_m <= 0;
        end else begin
            rem <= n_rem;
            owe_d <= n_owe_d; owe_e <= n_owe_e; owe_m <= n_owe_m;
        end
    end

    initial begin
        rst = 1;
        applyStimulus();
        applyStimulus();
        rst = 0;
        @(negedge clk);
        checkOutput("reset_busy", {32'd0, sb_busy}, 64'd0);
        checkOutput("reset_stallD", {63'd0, stallD}, 64'd0);

        // Forwarding: MEM beats WB, register 0 never forwarded.
        applyStimulus();
        srcE = {5'd0, 5'd3}; regwriteM = 1; writeregM = 5'd3; regwriteW = 1; writeregW = 5'd3;
        @(negedge clk);
        checkOutput("fwd_mem_prio", {60'd0, forwardE}, 64'h1);
        applyStimulus();
        srcE = {5'd0, 5'd0}; regwriteM = 1; writeregM = 5'd0;
        @(negedge clk);
        checkOutput("fwd_r0", {60'd0, forwardE}, 64'h0);
        applyStimulus();
        srcE = {5'd7, 5'd2}; regwriteW = 1; writeregW = 5'd7;
        @(negedge clk);
        checkOutput("fwd_wb_ch1", {60'd0, forwardE}, 64'h8);

        // Load-use on channel 1.
        applyStimulus();
        mem_readE = 1; regwriteE = 1; writeregE = 5'd8; srcD = {5'd8, 5'd0}; src_validD = 2'b10;
        @(negedge clk);
        checkOutput("lu_stalls", {60'd0, stallF, stallD, flushE, stallE}, 64'hE);
        applyStimulus();
        @(negedge clk);
        checkOutput("lu_after", {62'd0, stallD, flushE}, 64'd0);

        // Scoreboard: issue r5 lat 4, dependent in D.
        applyStimulus();
        lat_issueE = 1; regwriteE = 1; writeregE = 5'd5; lat_cyclesE = 6'd4;
        @(negedge clk);
        checkOutput("sb_not_yet", {63'd0, sb_busy[5]}, 64'd0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus();
            srcD = {5'd0, 5'd5}; src_validD = 2'b01;
            @(negedge clk);
            checkOutput("sb_busy5", {63'd0, sb_busy[5]}, (i <= 4) ? 64'd1 : 64'd0);
            checkOutput("sb_stallD", {63'd0, stallD}, (i <= 4) ? 64'd1 : 64'd0);
        end

        // Re-issue at cycle 2 with lat 3 extends busy through cycle 5.
        applyStimulus();
        lat_issueE = 1; regwriteE = 1; writeregE = 5'd5; lat_cyclesE = 6'd4;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus();
            if (i == 2) begin
                lat_issueE = 1; regwriteE = 1; writeregE = 5'd5; lat_cyclesE = 6'd3;
            end
            @(negedge clk);
            checkOutput("sb_reissue", {63'd0, sb_busy[5]}, (i <= 5) ? 64'd1 : 64'd0);
        end

        // Countdown freezes while W is stalled; exception blocks a new issue.
        applyStimulus();
        lat_issueE = 1; regwriteE = 1; writeregE = 5'd6; lat_cyclesE = 6'd2;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus();
            d_cache_stall = (i <= 2);
            @(negedge clk);
            checkOutput("sb_freeze", {63'd0, sb_busy[6]}, (i <= 4) ? 64'd1 : 64'd0);
        end
        applyStimulus();
        lat_issueE = 1; regwriteE = 1; writeregE = 5'd9; lat_cyclesE = 6'd3; flush_exceptionM = 1;
        applyStimulus();
        @(negedge clk);
        checkOutput("sb_exc_block", {63'd0, sb_busy[9]}, 64'd0);

        // Replay: exception during a 3-cycle d-cache stall.
        for (int i = 0; i <= 4; i++) begin
            applyStimulus();
            d_cache_stall = (i <= 2);
            flush_exceptionM = (i == 0);
            @(negedge clk);
            checkOutput("replay_flushM", {63'd0, flushM}, (i == 3) ? 64'd1 : 64'd0);
        end

        // Reset mid-operation drops busy bits and the pending D flush.
        applyStimulus();
        lat_issueE = 1; regwriteE = 1; writeregE = 5'd5; lat_cyclesE = 6'd20;
        applyStimulus();
        i_cache_stall = 1; flush_pred_failedM = 1;
        applyStimulus();
        i_cache_stall = 1;
        @(negedge clk);
        checkOutput("pre_rst_busy", {63'd0, sb_busy[5]}, 64'd1);
        #2 rst = 1;
        #1 checkOutput("async_rst_busy", {32'd0, sb_busy}, 64'd0);
        applyStimulus();
        rst = 0;
        @(negedge clk);
        checkOutput("post_rst_noreplay", {63'd0, flushD}, 64'd0);

`ifdef HAZARD_PERF_CNT_EN
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            d_cache_stall = 1;
        end
        applyStimulus();
        @(negedge clk);
        checkOutput("perf_dc_cnt", {32'd0, perf_dc_cnt}, 64'd10);
`endif

        applyStimulus();
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
